shake_cmd_sequencer: RTL and testbench
======================================

Name: shake_cmd_sequencer

Overview:
Command-side initiator for the SHA/SHAKE wrapper. It accepts one hash request (mode, input/output base addresses, byte lengths) and drives the wrapper's command port in the required order: length write, state clear, absorb, then squeeze. It waits on done_shake between phases and reports completion or timeout. It sits between the Saber top-level controller and the Keccak core wrapper, replacing hand-sequenced command writes.

Parameters:
TIMEOUT_CYCLES, 4096, max cycles spent in any wait state before error abort
CNT_W, 13, width of timeout counter (must hold TIMEOUT_CYCLES)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  sequencer idle and accepting
req_mode  in  9  mode/rate selector placed in command_in[31:23] (16 = SHAKE128)
req_in_addr  in  9  input base word address, command_in[22:14]
req_out_addr  in  9  output base word address, command_in[13:5]
req_in_len  in  16  input length in bytes
req_out_len  in  16  output length in bytes
command_in  out  32  command word to wrapper
command_we0  out  1  write opcode word
command_we1  out  1  write length word
command_enable  out  1  start latched command
done_shake  in  1  wrapper phase complete (level or pulse)
seq_done  out  1  one-cycle pulse, sequence finished OK
seq_error  out  1  sticky timeout flag, cleared on next accepted request
busy  out  1  high from accept until seq_done or error

Behaviour:
- All outputs registered. Reset: state IDLE, command_in=0, we0/we1/enable=0, seq_done=0, seq_error=0, busy=0, req_ready=1. Reset is asserted asynchronously mid-sequence, returns to IDLE immediately, and issues no further commands.
- req_ready=1 only in IDLE. Accept on req_valid&&req_ready; fields latched. Requests while busy are not accepted.
- Opcode word = {mode, in_addr, out_addr, op}; ops: 0 = clear, 3 = absorb, 4 = squeeze. Length word = {out_len, in_len}.
- At most one of we0/we1/enable high per cycle. command_in is 0 on enable cycles and in idle/wait states.
- States, one cycle each unless noted, relative to accept cycle T:
  T+1 WR_LEN: we1=1, length word.
  T+2 WR_CLR: we0=1, op 0.
  T+3 EN_CLR: enable=1. No done wait follows.
  T+4 WR_ABS: we0=1, op 3.
  T+5 EN_ABS: enable=1.
  T+6.. WAIT_ABS: done_shake ignored in the first wait cycle (stale level from the previous phase). Later, done_shake=1 leads to WR_SQZ, or to FINISH if out_len==0.
  WR_SQZ: we0=1, op 4. EN_SQZ: enable=1. WAIT_SQZ: same rules as WAIT_ABS, then FINISH.
  FINISH: seq_done=1 for one cycle, busy=0, next state IDLE.
- in_len==0: absorb still issued (padding-only block).
- Timeout: a counter clears on entering each wait state and increments per cycle. Reaching TIMEOUT_CYCLES-1 without done leads to ERR: seq_error=1, busy=0, no seq_done, then IDLE. seq_error stays set until the next accept.
- done_shake outside wait states is ignored.
- Minimum latency, accept to seq_done with done on the second wait cycle: T+12.

Decomposition:
- Shared keccak command package: op codes (OP_CLEAR=0, OP_ABSORB=3, OP_SQUEEZE=4), field bit positions/widths of the opcode and length words, MODE_SHAKE128=16, and a state enum.
- Optional sub-module shake_cmd_pack (combinational word formatter). The FSM stays in one module.

Test Plan:
- Basic: mode 16, addrs 0/0, in_len 32, out_len 336; done on 2nd wait cycle each phase. Required words in order: we1 0x01500020, we0 0x08000000, enable, we0 0x08000003, enable, we0 0x08000004, enable. Required result: seq_done pulse at T+12.
- Addressing: in_addr 4, out_addr 8, rest as basic. Required absorb word 0x08010103, squeeze word 0x08010104.
- Stale done: done_shake held high across EN_ABS and the first wait cycle, then low, then pulsed at wait cycle 5. Required: the sequencer advances only on the cycle-5 pulse.
- out_len 0: no squeeze word issued. Required: seq_done on the cycle after absorb done.
- Timeout: TIMEOUT_CYCLES=16, done never asserted. Required: seq_error=1 within 16 wait cycles, busy=0, req_ready=1. The next accepted request clears seq_error.
- Reset mid-WAIT_ABS: rst_n low for 1 cycle. Required: all outputs return to reset values immediately, no enable is issued afterwards, and a new request runs normally.

Source files
------------

// File: rtl/shake_cmd_sequencer_pkg.sv
// rtl/shake_cmd_sequencer_pkg.sv - shared Keccak wrapper command definitions
// Purpose: opcode values, command/length word field layout, mode constants and
// the sequencer state encoding shared by the sequencer, its formatter and the interfaces.
package shake_cmd_sequencer_pkg;

    localparam int MODE_W = 9;
    localparam int ADDR_W = 9;
    localparam int OP_W   = 5;
    localparam int LEN_W  = 16;
    localparam int WORD_W = 32;

    // Opcode word layout: {mode[31:23], in_addr[22:14], out_addr[13:5], op[4:0]}
    localparam int MODE_LSB     = 23;
    localparam int IN_ADDR_LSB  = 14;
    localparam int OUT_ADDR_LSB = 5;
    localparam int OP_LSB       = 0;

    // Length word layout: {out_len[31:16], in_len[15:0]}
    localparam int IN_LEN_LSB  = 0;
    localparam int OUT_LEN_LSB = 16;

    localparam logic [OP_W-1:0]   OP_CLEAR      = 5'd0;
    localparam logic [OP_W-1:0]   OP_ABSORB     = 5'd3;
    localparam logic [OP_W-1:0]   OP_SQUEEZE    = 5'd4;
    localparam logic [MODE_W-1:0] MODE_SHAKE128 = 9'd16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_LEN,
        S_WR_CLR,
        S_EN_CLR,
        S_WR_ABS,
        S_EN_ABS,
        S_WAIT_ABS,
        S_WR_SQZ,
        S_EN_SQZ,
        S_WAIT_SQZ,
        S_FINISH,
        S_ERR
    } seq_state_e;

endpackage

// File: rtl/shake_cmd_sequencer_if.sv
// rtl/shake_cmd_sequencer_if.sv - request and wrapper command interfaces
// Purpose: shake_req_if carries one hash request (valid/ready plus fields);
// shake_cmd_if carries the wrapper command port (command_in, we0, we1, enable)
// and the wrapper's done_shake back to the initiator.
interface shake_req_if;
    import shake_cmd_sequencer_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [MODE_W-1:0] req_mode;
    logic [ADDR_W-1:0] req_in_addr;
    logic [ADDR_W-1:0] req_out_addr;
    logic [LEN_W-1:0]  req_in_len;
    logic [LEN_W-1:0]  req_out_len;

    modport master (
        output req_valid, req_mode, req_in_addr, req_out_addr, req_in_len, req_out_len,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_mode, req_in_addr, req_out_addr, req_in_len, req_out_len,
        output req_ready
    );
endinterface

interface shake_cmd_if;
    import shake_cmd_sequencer_pkg::*;

    logic [WORD_W-1:0] command_in;
    logic              command_we0;
    logic              command_we1;
    logic              command_enable;
    logic              done_shake;

    modport master (
        output command_in, command_we0, command_we1, command_enable,
        input  done_shake
    );

    modport slave (
        input  command_in, command_we0, command_we1, command_enable,
        output done_shake
    );
endinterface

// File: rtl/shake_cmd_sequencer_pack.sv
// rtl/shake_cmd_sequencer_pack.sv - combinational command/length word formatter
// Purpose: builds the opcode word and the length word from request fields.
// Ports: mode_i, in_addr_i, out_addr_i, op_i, in_len_i, out_len_i in;
//        op_word_o, len_word_o out.
module shake_cmd_sequencer_pack
    import shake_cmd_sequencer_pkg::*;
(
    input  logic [MODE_W-1:0] mode_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    input  logic [ADDR_W-1:0] out_addr_i,
    input  logic [OP_W-1:0]   op_i,
    input  logic [LEN_W-1:0]  in_len_i,
    input  logic [LEN_W-1:0]  out_len_i,
    output logic [WORD_W-1:0] op_word_o,
    output logic [WORD_W-1:0] len_word_o
);
    always_comb begin
        op_word_o = '0;
        op_word_o[MODE_LSB     +: MODE_W] = mode_i;
        op_word_o[IN_ADDR_LSB  +: ADDR_W] = in_addr_i;
        op_word_o[OUT_ADDR_LSB +: ADDR_W] = out_addr_i;
        op_word_o[OP_LSB       +: OP_W]   = op_i;

        len_word_o = '0;
        len_word_o[IN_LEN_LSB  +: LEN_W] = in_len_i;
        len_word_o[OUT_LEN_LSB +: LEN_W] = out_len_i;
    end
endmodule

// File: rtl/shake_cmd_sequencer.sv
// rtl/shake_cmd_sequencer.sv - SHA/SHAKE wrapper command sequencer
// Purpose: accepts one hash request and issues length, clear, absorb and squeeze
// commands to the Keccak wrapper, waiting on done_shake between phases.
// Ports: clk, rst_n (async active-low); req (request slave); cmd (wrapper
//        command master); seq_done (1-cycle pulse), seq_error (sticky timeout), busy.
module shake_cmd_sequencer
    import shake_cmd_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic        clk,
    input  logic        rst_n,
    shake_req_if.slave  req,
    shake_cmd_if.master cmd,
    output logic        seq_done,
    output logic        seq_error,
    output logic        busy
);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_e        state_q;
    logic [WORD_W-1:0] cmd_q;
    logic              we0_q, we1_q, en_q;
    logic              done_q, err_q, busy_q, ready_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [MODE_W-1:0] mode_q;
    logic [ADDR_W-1:0] in_addr_q, out_addr_q;
    logic              out_len_zero_q;

    logic [OP_W-1:0]   op_sel;
    logic [WORD_W-1:0] op_word, len_word;

    // The opcode word is registered one state ahead of the write, so select
    // the op for the write state that follows the current state.
    always_comb begin
        op_sel = OP_CLEAR;
        if (state_q == S_EN_CLR) begin
            op_sel = OP_ABSORB;
        end else if (state_q == S_WAIT_ABS) begin
            op_sel = OP_SQUEEZE;
        end
    end

    // Lengths are only needed on the accept cycle, so they come straight
    // from the request rather than from latched copies.
    shake_cmd_sequencer_pack u_pack (
        .mode_i     (mode_q),
        .in_addr_i  (in_addr_q),
        .out_addr_i (out_addr_q),
        .op_i       (op_sel),
        .in_len_i   (req.req_in_len),
        .out_len_i  (req.req_out_len),
        .op_word_o  (op_word),
        .len_word_o (len_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cmd_q          <= '0;
            we0_q          <= 1'b0;
            we1_q          <= 1'b0;
            en_q           <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            busy_q         <= 1'b0;
            ready_q        <= 1'b1;
            cnt_q          <= '0;
            mode_q         <= '0;
            in_addr_q      <= '0;
            out_addr_q     <= '0;
            out_len_zero_q <= 1'b0;
        end else begin
            cmd_q  <= '0;
            we0_q  <= 1'b0;
            we1_q  <= 1'b0;
            en_q   <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            case (state_q)
                S_IDLE: begin
                    if (req.req_valid && ready_q) begin
                        mode_q         <= req.req_mode;
                        in_addr_q      <= req.req_in_addr;
                        out_addr_q     <= req.req_out_addr;
                        out_len_zero_q <= (req.req_out_len == '0);
                        state_q        <= S_WR_LEN;
                        we1_q          <= 1'b1;
                        cmd_q          <= len_word;
                        busy_q         <= 1'b1;
                        ready_q        <= 1'b0;
                        err_q          <= 1'b0;
                    end
                end
                S_WR_LEN: begin
                    state_q <= S_WR_CLR;
                    we0_q   <= 1'b1;
                    cmd_q   <= op_word;
                end
                S_WR_CLR: begin
                    state_q <= S_EN_CLR;
                    en_q    <= 1'b1;
                end
                S_EN_CLR: begin
                    state_q <= S_WR_ABS;
                    we0_q   <= 1'b1;
                    cmd_q   <= op_word;
                end
                S_WR_ABS: begin
                    state_q <= S_EN_ABS;
                    en_q    <= 1'b1;
                end
                S_EN_ABS: begin
                    state_q <= S_WAIT_ABS;
                end
                S_WAIT_ABS: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // cnt_q == 0 marks the first wait cycle, where done_shake
                    // may still be the level left over from the previous phase.
                    if ((cnt_q != '0) && cmd.done_shake) begin
                        if (out_len_zero_q) begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_WR_SQZ;
                            we0_q   <= 1'b1;
                            cmd_q   <= op_word;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                S_WR_SQZ: begin
                    state_q <= S_EN_SQZ;
                    en_q    <= 1'b1;
                end
                S_EN_SQZ: begin
                    state_q <= S_WAIT_SQZ;
                end
                S_WAIT_SQZ: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if ((cnt_q != '0) && cmd.done_shake) begin
                        state_q <= S_FINISH;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == TO_LAST) begin
                        state_q <= S_ERR;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                S_FINISH, S_ERR: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req.req_ready      = ready_q;
    assign cmd.command_in     = cmd_q;
    assign cmd.command_we0    = we0_q;
    assign cmd.command_we1    = we1_q;
    assign cmd.command_enable = en_q;
    assign seq_done           = done_q;
    assign seq_error          = err_q;
    assign busy               = busy_q;
endmodule

// File: tb/tb_shake_cmd_sequencer.sv
// tb/tb_shake_cmd_sequencer.sv - scoreboard bench for shake_cmd_sequencer
module tb_shake_cmd_sequencer;
    localparam int TMO = 16;

    localparam logic [4:0] K_LEN  = 5'b10000;
    localparam logic [4:0] K_OP   = 5'b01000;
    localparam logic [4:0] K_EN   = 5'b00100;
    localparam logic [4:0] K_DONE = 5'b00010;
    localparam logic [4:0] K_ERR  = 5'b00001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic seq_done, seq_error, busy;

    always #5 clk = ~clk;

    shake_req_if req_if ();
    shake_cmd_if cmd_if ();

    shake_cmd_sequencer #(
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (13)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_if),
        .cmd       (cmd_if),
        .seq_done  (seq_done),
        .seq_error (seq_error),
        .busy      (busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int compared = 0;
    int failed = 0;

    typedef struct {
        logic [4:0]  kind;
        logic [31:0] data;
        int          cyc;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        string       name;
        logic [8:0]  mode, ia, oa;
        logic [15:0] il, ol;
        logic [31:0] len_w, clr_w, abs_w, sqz_w;
        logic [63:0] mask;
        int          k, j, kind, run;
    } vec_t;

    function automatic vec_t mkv(input string n, input logic [8:0] mode, ia, oa,
                                 input logic [15:0] il, ol,
                                 input logic [31:0] lw, cw, aw, sw,
                                 input logic [63:0] mask, input int k, j, kind, run);
        vec_t v;
        v.name = n; v.mode = mode; v.ia = ia; v.oa = oa; v.il = il; v.ol = ol;
        v.len_w = lw; v.clr_w = cw; v.abs_w = aw; v.sqz_w = sw;
        v.mask = mask; v.k = k; v.j = j; v.kind = kind; v.run = run;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push(input string n, input logic [4:0] k, input logic [31:0] d, input int c);
        exp_t e;
        e.kind = k; e.data = d; e.cyc = c; e.name = n;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Monitor: every visible command/result event pops one expectation.
    logic [4:0] mk;
    logic       err_prev = 1'b0;
    exp_t       me;
    always @(negedge clk) begin
        if (rst_n) begin
            mk = {cmd_if.command_we1, cmd_if.command_we0, cmd_if.command_enable,
                  seq_done, seq_error && !err_prev};
            if (mk != 5'b0) begin
                compared++;
                if (exp_q.size() == 0) begin
                    failed++;
                    $display("FAIL unexpected_event: got kind=%b data=%h cyc=%0d, none expected",
                             mk, cmd_if.command_in, cyc);
                end else begin
                    me = exp_q.pop_front();
                    if (mk !== me.kind || cmd_if.command_in !== me.data || cyc != me.cyc) begin
                        failed++;
                        $display("FAIL %s: got kind=%b data=%h cyc=%0d, expected kind=%b data=%h cyc=%0d",
                                 me.name, mk, cmd_if.command_in, cyc, me.kind, me.data, me.cyc);
                    end
                end
            end
            err_prev = seq_error;
        end else begin
            err_prev = 1'b0;
        end
    end

    // kind: 0 normal, 1 timeout, 2 reset during absorb wait
    task automatic run_req(input vec_t v, input bit chk_clr);
        int t;
        step();
        chk({v.name, "/ready_idle"}, 64'(req_if.req_ready), 64'd1);
        t = cyc;
        req_if.req_mode     = v.mode;
        req_if.req_in_addr  = v.ia;
        req_if.req_out_addr = v.oa;
        req_if.req_in_len   = v.il;
        req_if.req_out_len  = v.ol;
        req_if.req_valid    = 1'b1;
        push({v.name, "/len"},     K_LEN, v.len_w, t + 1);
        push({v.name, "/clr"},     K_OP,  v.clr_w, t + 2);
        push({v.name, "/en_clr"},  K_EN,  32'h0,   t + 3);
        push({v.name, "/abs"},     K_OP,  v.abs_w, t + 4);
        push({v.name, "/en_abs"},  K_EN,  32'h0,   t + 5);
        if (v.kind == 1) begin
            push({v.name, "/err"}, K_ERR, 32'h0, t + 6 + TMO);
        end else if (v.kind == 0) begin
            if (v.ol == 16'd0) begin
                push({v.name, "/done"}, K_DONE, 32'h0, t + 6 + v.k);
            end else begin
                push({v.name, "/sqz"},    K_OP,   v.sqz_w, t + 6 + v.k);
                push({v.name, "/en_sqz"}, K_EN,   32'h0,   t + 7 + v.k);
                push({v.name, "/done"},   K_DONE, 32'h0,   t + 8 + v.k + v.j);
            end
        end
        for (int rel = 1; rel <= v.run; rel++) begin
            step();
            if (rel == 1) begin
                req_if.req_valid = 1'b0;
                chk({v.name, "/busy_not_ready"}, 64'({req_if.req_ready, busy}), 64'b01);
                if (chk_clr) chk({v.name, "/err_cleared"}, 64'(seq_error), 64'd0);
            end
            if (v.kind == 2 && rel == 8) begin
                rst_n = 1'b0;
                #1;
                chk({v.name, "/reset_outputs"},
                    64'({req_if.req_ready, busy, cmd_if.command_we0, cmd_if.command_we1,
                         cmd_if.command_enable, seq_done, seq_error, cmd_if.command_in}),
                    64'({1'b1, 38'd0}));
            end
            if (v.kind == 2 && rel == 9) rst_n = 1'b1;
            cmd_if.done_shake = (rel < 64) ? v.mask[rel] : 1'b0;
        end
        cmd_if.done_shake = 1'b0;
        if (v.kind == 1) begin
            chk({v.name, "/idle_status"}, 64'({req_if.req_ready, busy, seq_error}), 64'b101);
        end
        chk({v.name, "/all_events_seen"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        req_if.req_valid    = 1'b0;
        req_if.req_mode     = '0;
        req_if.req_in_addr  = '0;
        req_if.req_out_addr = '0;
        req_if.req_in_len   = '0;
        req_if.req_out_len  = '0;
        cmd_if.done_shake   = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_state",
            64'({req_if.req_ready, busy, cmd_if.command_we0, cmd_if.command_we1,
                 cmd_if.command_enable, seq_done, seq_error, cmd_if.command_in}),
            64'({1'b1, 38'd0}));
        rst_n = 1'b1;

        run_req(mkv("basic", 9'd16, 9'd0, 9'd0, 16'd32, 16'd336,
                    32'h01500020, 32'h08000000, 32'h08000003, 32'h08000004,
                    64'h880, 2, 2, 0, 14), 1'b0);
        run_req(mkv("addr", 9'd16, 9'd4, 9'd8, 16'd32, 16'd336,
                    32'h01500020, 32'h08010100, 32'h08010103, 32'h08010104,
                    64'h880, 2, 2, 0, 14), 1'b0);
        run_req(mkv("stale_done", 9'd16, 9'd0, 9'd0, 16'd32, 16'd336,
                    32'h01500020, 32'h08000000, 32'h08000003, 32'h08000004,
                    64'h4460, 5, 2, 0, 17), 1'b0);
        run_req(mkv("out_len0", 9'd16, 9'd0, 9'd0, 16'd32, 16'd0,
                    32'h00000020, 32'h08000000, 32'h08000003, 32'h0,
                    64'h80, 2, 0, 0, 10), 1'b0);
        run_req(mkv("wide_fields", 9'h0A8, 9'h1FF, 9'h1FF, 16'd0, 16'd64,
                    32'h00400000, 32'h547FFFE0, 32'h547FFFE3, 32'h547FFFE4,
                    64'h410C, 3, 4, 0, 17), 1'b0);
        run_req(mkv("timeout", 9'd16, 9'd0, 9'd0, 16'd32, 16'd336,
                    32'h01500020, 32'h08000000, 32'h08000003, 32'h08000004,
                    64'h0, 0, 0, 1, 24), 1'b0);
        run_req(mkv("after_timeout", 9'd16, 9'd0, 9'd0, 16'd32, 16'd336,
                    32'h01500020, 32'h08000000, 32'h08000003, 32'h08000004,
                    64'h880, 2, 2, 0, 14), 1'b1);
        run_req(mkv("reset_wait", 9'd16, 9'd0, 9'd0, 16'd32, 16'd336,
                    32'h01500020, 32'h08000000, 32'h08000003, 32'h08000004,
                    64'h1800, 0, 0, 2, 16), 1'b0);
        run_req(mkv("after_reset", 9'd16, 9'd4, 9'd8, 16'd32, 16'd336,
                    32'h01500020, 32'h08010100, 32'h08010103, 32'h08010104,
                    64'h880, 2, 2, 0, 14), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
